// File: rtl/lsu_mem_ctrl.sv
// Two-port load/store arbiter in front of a single-port data memory, with p1 lock ownership.
// Define LSU_MEM_CTRL_MISALIGN_EN to let word-crossing accesses execute; o_mem_wdata is byte-lane rotated.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [2:0]  i_p0_func3,
    input  logic [15:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [2:0]  i_p1_func3,
    input  logic [15:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic        i_p1_lock,
    output logic        o_p0_gnt,
    output logic        o_p0_rvalid,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_err,
    output logic        o_p1_gnt,
    output logic        o_p1_rvalid,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_err,
    output logic [2:0]  o_mem_func3,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask_align,
    output logic [3:0]  o_mem_bmask_misalign,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [8:0] TOP_WORD = 9'(MEM_WORDS - 1);

    state_t      state;
    logic        prio_p1;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_err;
    logic        rsp_load;

    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        sel_we;
    logic [2:0]  sel_func3;
    logic [15:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rot_wdata;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic        crosses;
    logic        misalign_bad;
    logic        illegal;
    logic        legal;

    // Grants are gated by reset so every output reads zero while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_reset) begin
            if (state == LOCK) begin
                gnt1 = i_p1_req;
            end else if (i_p0_req && i_p1_req) begin
                gnt1 = prio_p1;
                gnt0 = !prio_p1;
            end else begin
                gnt0 = i_p0_req;
                gnt1 = i_p1_req;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? i_p1_we    : i_p0_we;
    assign sel_func3 = gnt1 ? i_p1_func3 : i_p0_func3;
    assign sel_addr  = gnt1 ? i_p1_addr  : i_p0_addr;
    assign sel_wdata = gnt1 ? i_p1_wdata : i_p0_wdata;

    always_comb begin
        size_mask = 4'b0000;
        case (sel_func3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    assign lane_mask = {4'b0000, size_mask} << sel_addr[1:0];
    assign crosses   = (lane_mask[7:4] != 4'b0000);

`ifdef LSU_MEM_CTRL_MISALIGN_EN
    assign misalign_bad = crosses && (sel_addr[10:2] == TOP_WORD);
`else
    assign misalign_bad = crosses;
`endif

    assign illegal = (sel_func3[1:0] == 2'b11) || (sel_func3[2:1] == 2'b11)
                   || (sel_we && sel_func3[2]) || misalign_bad;
    assign legal   = any_gnt && !illegal;

    // Store data is rotated so byte k of the request lands on lane (addr+k) mod 4.
    always_comb begin
        rot_wdata = sel_wdata;
        case (sel_addr[1:0])
            2'd1:    rot_wdata = {sel_wdata[23:0], sel_wdata[31:24]};
            2'd2:    rot_wdata = {sel_wdata[15:0], sel_wdata[31:16]};
            2'd3:    rot_wdata = {sel_wdata[7:0],  sel_wdata[31:8]};
            default: rot_wdata = sel_wdata;
        endcase
    end

    assign o_p0_gnt             = gnt0;
    assign o_p1_gnt             = gnt1;
    assign o_mem_func3          = any_gnt ? sel_func3 : 3'b000;
    assign o_mem_addr           = any_gnt ? sel_addr  : 16'h0000;
    assign o_mem_wdata          = any_gnt ? rot_wdata : 32'h0000_0000;
    assign o_mem_bmask_align    = legal ? lane_mask[3:0] : 4'b0000;
    assign o_mem_bmask_misalign = legal ? lane_mask[7:4] : 4'b0000;
    assign o_mem_wren           = legal && sel_we;
    assign o_mem_rden           = legal && !sel_we;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ARB;
            prio_p1   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_id    <= gnt1;
            rsp_err   <= any_gnt && illegal;
            rsp_load  <= legal && !sel_we;
            if (any_gnt) begin
                prio_p1 <= gnt0;
            end
            case (state)
                ARB:     if (gnt1 && i_p1_lock) state <= LOCK;
                LOCK:    if (!i_p1_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    assign o_p0_rvalid = rsp_valid && !rsp_id;
    assign o_p1_rvalid = rsp_valid && rsp_id;
    assign o_p0_err    = o_p0_rvalid && rsp_err;
    assign o_p1_err    = o_p1_rvalid && rsp_err;
    assign o_p0_rdata  = (o_p0_rvalid && rsp_load) ? i_mem_rdata : 32'h0000_0000;
    assign o_p1_rdata  = (o_p1_rvalid && rsp_load) ? i_mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed steps plus random traffic against a byte-level model.
// Honours LSU_MEM_CTRL_MISALIGN_EN the same way the design does.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_p0_req = 1'b0, i_p0_we = 1'b0;
    logic [2:0]  i_p0_func3 = 3'd0;
    logic [15:0] i_p0_addr = 16'd0;
    logic [31:0] i_p0_wdata = 32'd0;
    logic        i_p1_req = 1'b0, i_p1_we = 1'b0, i_p1_lock = 1'b0;
    logic [2:0]  i_p1_func3 = 3'd0;
    logic [15:0] i_p1_addr = 16'd0;
    logic [31:0] i_p1_wdata = 32'd0;
    logic        o_p0_gnt, o_p0_rvalid, o_p0_err, o_p1_gnt, o_p1_rvalid, o_p1_err;
    logic [31:0] o_p0_rdata, o_p1_rdata, o_mem_wdata;
    logic [2:0]  o_mem_func3;
    logic [15:0] o_mem_addr;
    logic [3:0]  o_mem_bmask_align, o_mem_bmask_misalign;
    logic        o_mem_wren, o_mem_rden;
    bit   [31:0] mem_rdata;

    bit   [31:0] tb_mem [0:511];
    bit   [31:0] nw0, nw1;
    bit   [7:0]  model_mem [0:2047];

    int          n_total = 0;
    int          n_pass = 0;
    bit          pend_v = 0;
    int          pend_port = 0;
    bit          pend_err = 0;
    logic [31:0] pend_data = 0;
    bit          m_locked = 0;
    int          m_last = 1;

`ifdef LSU_MEM_CTRL_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    lsu_mem_ctrl #(.MEM_WORDS(512)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_func3(i_p0_func3),
        .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
        .i_p1_req(i_p1_req), .i_p1_we(i_p1_we), .i_p1_func3(i_p1_func3),
        .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata), .i_p1_lock(i_p1_lock),
        .o_p0_gnt(o_p0_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata), .o_p0_err(o_p0_err),
        .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata), .o_p1_err(o_p1_err),
        .o_mem_func3(o_mem_func3), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask_align(o_mem_bmask_align), .o_mem_bmask_misalign(o_mem_bmask_misalign),
        .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised data memory: byte-lane writes, one-cycle read latency.
    always @(posedge clk) begin
        nw0 = tb_mem[o_mem_addr[10:2]];
        nw1 = tb_mem[o_mem_addr[10:2] + 9'd1];
        for (int b = 0; b < 4; b++) begin
            if (o_mem_bmask_align[b])    nw0[8*b +: 8] = o_mem_wdata[8*b +: 8];
            if (o_mem_bmask_misalign[b]) nw1[8*b +: 8] = o_mem_wdata[8*b +: 8];
        end
        if (o_mem_wren) begin
            tb_mem[o_mem_addr[10:2]] <= nw0;
            if (o_mem_bmask_misalign != 4'b0000) tb_mem[o_mem_addr[10:2] + 9'd1] <= nw1;
        end
        if (o_mem_rden) mem_rdata <= tb_mem[o_mem_addr[10:2]];
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Access described by byte count and offset rather than by mask shifting.
    task automatic model_decode(input logic we, input logic [2:0] f3, input logic [15:0] a,
                                output bit legal, output logic [3:0] al, output logic [3:0] mis);
        int  nbytes = 1 << int'(f3[1:0]);
        int  off = int'(a[1:0]);
        bit  bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
        bit  crosses = (off + nbytes) > 4;
        bit  top = (int'(a[10:2]) == 511);
        al = 4'b0000;
        mis = 4'b0000;
        legal = !bad_f3 && !(crosses && (!MISALIGN_EN || top));
        if (legal) begin
            for (int k = 0; k < nbytes; k++) begin
                if (off + k < 4) al[off + k] = 1'b1;
                else mis[off + k - 4] = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input bit r0, input bit w0, input logic [2:0] f0, input logic [15:0] a0,
                                  input logic [31:0] d0, input bit r1, input bit w1, input logic [2:0] f1,
                                  input logic [15:0] a1, input logic [31:0] d1, input bit lk);
        int          g;
        bit          legal, we;
        logic [2:0]  f3;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  al, mis;
        int          base;
        @(negedge clk);
        i_p0_req = r0; i_p0_we = w0; i_p0_func3 = f0; i_p0_addr = a0; i_p0_wdata = d0;
        i_p1_req = r1; i_p1_we = w1; i_p1_func3 = f1; i_p1_addr = a1; i_p1_wdata = d1;
        i_p1_lock = lk;
        #1;
        check_output("p0_rvalid", 32'(o_p0_rvalid), 32'(pend_v && pend_port == 0));
        check_output("p1_rvalid", 32'(o_p1_rvalid), 32'(pend_v && pend_port == 1));
        check_output("p0_err", 32'(o_p0_err), 32'(pend_v && pend_port == 0 && pend_err));
        check_output("p1_err", 32'(o_p1_err), 32'(pend_v && pend_port == 1 && pend_err));
        check_output("p0_rdata", o_p0_rdata, (pend_v && pend_port == 0) ? pend_data : 32'd0);
        check_output("p1_rdata", o_p1_rdata, (pend_v && pend_port == 1) ? pend_data : 32'd0);
        g = -1;
        if (m_locked) begin
            if (r1) g = 1;
        end else if (r0 && r1) g = (m_last == 1) ? 0 : 1;
        else if (r0) g = 0;
        else if (r1) g = 1;
        check_output("p0_gnt", 32'(o_p0_gnt), 32'(g == 0));
        check_output("p1_gnt", 32'(o_p1_gnt), 32'(g == 1));
        pend_v = (g >= 0);
        pend_data = 32'd0;
        if (g >= 0) begin
            we = (g == 1) ? w1 : w0;
            f3 = (g == 1) ? f1 : f0;
            a  = (g == 1) ? a1 : a0;
            d  = (g == 1) ? d1 : d0;
            model_decode(we, f3, a, legal, al, mis);
            check_output("mem_addr", 32'(o_mem_addr), 32'(a));
            check_output("mem_wren", 32'(o_mem_wren), 32'(legal && we));
            check_output("mem_rden", 32'(o_mem_rden), 32'(legal && !we));
            check_output("mem_align", 32'(o_mem_bmask_align), 32'(al));
            check_output("mem_misalign", 32'(o_mem_bmask_misalign), 32'(mis));
            pend_port = g;
            pend_err = !legal;
            base = int'(a[10:0]);
            if (legal && we) begin
                for (int k = 0; k < (1 << int'(f3[1:0])); k++) model_mem[base + k] = d[8*k +: 8];
            end else if (legal) begin
                base = base & ~3;
                pend_data = {model_mem[base + 3], model_mem[base + 2], model_mem[base + 1], model_mem[base]};
            end
            m_last = g;
        end else begin
            check_output("mem_wren_idle", 32'(o_mem_wren), 32'd0);
            check_output("mem_rden_idle", 32'(o_mem_rden), 32'd0);
        end
        if (!m_locked && g == 1 && lk) m_locked = 1;
        else if (m_locked && !lk) m_locked = 0;
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 3'd0, 16'd0, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
    endtask

    // Reset lands just after a clock edge so any response captured there must be dropped.
    task automatic do_reset();
        @(posedge clk);
        #1 i_reset = 1'b0;
        pend_v = 0; m_locked = 0; m_last = 1;
        #1;
        check_output("rst_gnt", 32'({o_p0_gnt, o_p1_gnt}), 32'd0);
        check_output("rst_rvalid", 32'({o_p0_rvalid, o_p1_rvalid}), 32'd0);
        check_output("rst_err", 32'({o_p0_err, o_p1_err}), 32'd0);
        check_output("rst_rdata", o_p0_rdata | o_p1_rdata, 32'd0);
        check_output("rst_mem_ctl", 32'({o_mem_wren, o_mem_rden, o_mem_bmask_align, o_mem_bmask_misalign}), 32'd0);
        check_output("rst_mem_bus", 32'(o_mem_addr) | o_mem_wdata | 32'(o_mem_func3), 32'd0);
        i_p0_req = 0; i_p1_req = 0; i_p1_lock = 0;
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    initial begin
        i_p0_req = 1;
        i_p1_req = 1;
        do_reset();

        apply_stimulus(1, 1, 3'b010, 16'h0010, 32'hDEADBEEF, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("sw_align", 32'(o_mem_bmask_align), 32'h0000000F);
        check_output("sw_misalign", 32'(o_mem_bmask_misalign), 32'd0);
        apply_stimulus(1, 0, 3'b010, 16'h0010, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("lw_rden", 32'(o_mem_rden), 32'd1);
        idle();
        check_output("lw_rvalid", 32'(o_p0_rvalid), 32'd1);
        check_output("lw_rdata", o_p0_rdata, 32'hDEADBEEF);
        check_output("lw_err", 32'(o_p0_err), 32'd0);

        apply_stimulus(1, 1, 3'b001, 16'h0013, 32'h0000ABCD, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("sh_align", 32'(o_mem_bmask_align), MISALIGN_EN ? 32'h8 : 32'h0);
        check_output("sh_misalign", 32'(o_mem_bmask_misalign), MISALIGN_EN ? 32'h1 : 32'h0);
        check_output("sh_wren", 32'(o_mem_wren), 32'(MISALIGN_EN));
        apply_stimulus(1, 0, 3'b010, 16'h07FE, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("sh_err", 32'(o_p0_err), 32'(!MISALIGN_EN));
        check_output("top_rden", 32'(o_mem_rden), 32'd0);
        apply_stimulus(1, 0, 3'b011, 16'h0020, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("top_err", 32'(o_p0_err), 32'd1);
        idle();
        check_output("f3_011_err", 32'(o_p0_err), 32'd1);

        apply_stimulus(1, 0, 3'b010, 16'h0010, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        do_reset();
        idle();
        check_output("post_rst_rvalid", 32'(o_p0_rvalid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 3'b010, 16'h0010, 32'd0, 1, 0, 3'b010, 16'h0014, 32'd0, 0);
            check_output("rr_p1_gnt", 32'(o_p1_gnt), 32'((i % 2) == 1));
        end

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 3'b000, 16'h0011, 32'd0, 1, 1, 3'b000, 16'h0030, 32'(i), 1);
            check_output("lock_p0_gnt", 32'(o_p0_gnt), 32'd0);
        end
        apply_stimulus(1, 0, 3'b000, 16'h0011, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("unlock_p0_wait", 32'(o_p0_gnt), 32'd0);
        apply_stimulus(1, 0, 3'b000, 16'h0011, 32'd0, 0, 0, 3'd0, 16'd0, 32'd0, 0);
        check_output("unlock_p0_gnt", 32'(o_p0_gnt), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra0, ra1;
            ra0 = ($urandom_range(0, 4) == 0) ? 16'(12'h7F8 + $urandom_range(0, 7)) : 16'($urandom_range(0, 63));
            ra1 = ($urandom_range(0, 4) == 0) ? 16'(12'h7F8 + $urandom_range(0, 7)) : 16'($urandom_range(0, 63));
            apply_stimulus(1'($urandom), 1'($urandom), 3'($urandom), ra0, $urandom,
                           1'($urandom), 1'($urandom), 3'($urandom), ra1, $urandom,
                           $urandom_range(0, 3) == 0);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, number of 32-bit memory words addressed by o_mem_addr[10:2].
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports i_pN_req, input, 1, request valid from requester N (N=0 core LSU, N=1 debug/loader).
REQ-005 SHALL have ports i_pN_we, input, 1, 1=store, 0=load.
REQ-006 SHALL have ports i_pN_func3, input, 3, RISC-V load/store func3.
REQ-007 SHALL have ports i_pN_addr, input, 16, byte address.
REQ-008 SHALL have ports i_pN_wdata, input, 32, store data, LSB-justified.
REQ-009 SHALL have port i_p1_lock, input, 1, requester 1 asks for exclusive ownership.
REQ-010 SHALL have ports o_pN_gnt, output, 1, request accepted this cycle.
REQ-011 SHALL have ports o_pN_rvalid, output, 1, response pulse for a granted request.
REQ-012 SHALL have ports o_pN_rdata, output, 32, load data, valid with o_pN_rvalid.
REQ-013 SHALL have ports o_pN_err, output, 1, request was illegal; valid with o_pN_rvalid.
REQ-014 SHALL have ports o_mem_func3 (3), o_mem_addr (16), o_mem_wdata (32), o_mem_bmask_align (4), o_mem_bmask_misalign (4), o_mem_wren (1), o_mem_rden (1), all outputs driving the data memory.
REQ-015 SHALL have port i_mem_rdata, input, 32, memory load data, valid the cycle after o_mem_rden.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt combinational from req and state.
REQ-017 SHALL, in state ARB with both requesting, grant the requester not granted most recently (round-robin pointer; resets to favour p0).
REQ-018 SHALL transition ARB->LOCK when p1 is granted with i_p1_lock=1; in LOCK only p1 is granted; LOCK->ARB on the first cycle i_p1_lock=0.
REQ-019 SHALL drive o_mem_* combinationally from the granted request; wren/rden/masks 0 when no grant or request illegal.
REQ-020 SHALL compute size mask 0001/0011/1111 for func3[1:0]=00/01/10; {misalign,align} = (size mask << addr[1:0]), 8 bits.
REQ-021 SHALL flag illegal: func3 011/11x; store with func3[2]=1; any access with nonzero misalign mask and addr[10:2]=MEM_WORDS-1 (top-word wrap).
REQ-022 SHALL produce exactly one o_pN_rvalid pulse, one cycle after each grant (loads and stores), routed by a registered requester id.
REQ-023 SHALL pass o_pN_rdata = i_mem_rdata for legal loads, 0 otherwise; o_pN_err=1 only for illegal requests.
REQ-024 SHALL support back-to-back grants every cycle, including load after store to same address (memory returns the stored data).

Reset
REQ-025 SHALL, while i_reset=0: state ARB, pointer favours p0, pending response cleared, all outputs 0.
REQ-026 SHALL drop any in-flight response on reset assertion; no rvalid after release for pre-reset grants.

Configuration
REQ-027 SHALL honour macro LSU_MEM_CTRL_MISALIGN_EN: defined -> word-crossing accesses execute with misalign mask; undefined -> any nonzero misalign mask is illegal (err, no memory access).

Verification
REQ-028 p0 sw 0xDEADBEEF @0x0010 then lw @0x0010 -> align 1111, misalign 0000; rvalid next cycle, rdata 0xDEADBEEF, err 0.
REQ-029 sh 0xABCD @0x0013 -> align 1000, misalign 0001 (MISALIGN_EN); without macro -> err 1, wren 0.
REQ-030 p0 and p1 req every cycle, 4 cycles -> grants alternate p1,p0,p1,p0 after first p0; each rvalid to correct port.
REQ-031 p1 lock=1 for 3 cycles with p0 requesting -> p0 gnt 0 throughout; p0 granted cycle after lock drops.
REQ-032 lw @0x07FE (top word, crossing) -> err 1, rden 0; func3 011 -> err 1.
REQ-033 reset asserted cycle after a load grant -> no rvalid; all outputs 0 during reset.
